// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI byte slave front end.
//   SPI_BYTE_W        : width of one SPI byte
//   SPI_IDLE_TX_DEF   : default byte shifted out when no result is pending
//   spi_state_t       : slave state machine encoding
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int              SPI_BYTE_W      = 8;
  localparam logic [7:0]      SPI_IDLE_TX_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_byte_slave_if.sv
// -----------------------------------------------------------------------------
// spi_byte_slave_if
// Bundles the SPI pins and the grid-side byte handshake of spi_byte_slave.
//   sclk, cs_n, mosi : SPI pins driven by the host (asynchronous to clk)
//   miso             : serial result data back to the host
//   tx_data, tx_load : result byte and its one-cycle capture strobe
//   tx_pending       : a captured result byte is waiting for its byte slot
//   spi_input        : last complete received byte
//   spi_done         : one-cycle strobe marking a new spi_input
// Modports: slave (the SPI block), master (host pins + grid controller side).
// -----------------------------------------------------------------------------
interface spi_byte_slave_if;
  import spi_pkg::*;

  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_pending;
  logic [SPI_BYTE_W-1:0] spi_input;
  logic                  spi_done;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load,
    output miso, tx_pending, spi_input, spi_done
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load,
    input  miso, tx_pending, spi_input, spi_done
  );

endinterface

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// N-flop synchronizer for one asynchronous pin.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   rst_val_i : value every stage takes during reset (idle level of the pin)
//   d_i       : asynchronous input
//   q_o       : synchronized output, STAGES clk cycles behind d_i
// -----------------------------------------------------------------------------
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{rst_val_i}};
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_byte_slave.sv
// -----------------------------------------------------------------------------
// spi_byte_slave
// Mode-0 SPI slave running in the clk domain by oversampling the SPI pins.
// Each received byte is presented on spi_input with a one-cycle spi_done; a
// result byte captured via tx_load is shifted out on miso in the next byte slot.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : spi_byte_slave_if.slave (SPI pins + grid-side byte handshake)
// Parameters:
//   SYNC_STAGES  : synchronizer depth on sclk/cs_n/mosi (2 or 3)
//   IDLE_TX_BYTE : byte shifted out when no result is pending
// Build option:
//   SPI_BYTE_SLAVE_ECHO_EN : non-pending reloads send the last spi_input
//                            (loopback) instead of IDLE_TX_BYTE.
// -----------------------------------------------------------------------------
module spi_byte_slave
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] IDLE_TX_BYTE = SPI_IDLE_TX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  spi_byte_slave_if.slave   bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("spi_byte_slave: SYNC_STAGES must be 2 or 3");
  end

  // Synchronized pins; idle levels are cs_n=1, sclk=0, mosi=0.
  logic sclk_s, cs_n_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .rst_val_i(1'b0), .d_i(bus.sclk), .q_o(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .rst_val_i(1'b1), .d_i(bus.cs_n), .q_o(cs_n_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .rst_val_i(1'b0), .d_i(bus.mosi), .q_o(mosi_s));

  // Edge detection against a one-cycle delayed copy.
  logic sclk_prev_q, cs_n_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign cs_fall   = ~cs_n_s &  cs_n_prev_q;
  assign cs_rise   =  cs_n_s & ~cs_n_prev_q;

  spi_state_t            state_q;
  logic [2:0]            bit_cnt_q;
  logic [SPI_BYTE_W-1:0] rx_sh_q, tx_sh_q;
  logic [SPI_BYTE_W-1:0] spi_input_q;
  logic                  spi_done_q, miso_q;
  logic [SPI_BYTE_W-1:0] tx_pend_data_q;
  logic                  tx_pending_q;

  logic [SPI_BYTE_W-1:0] rx_d;
  logic [SPI_BYTE_W-1:0] reload_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rx_d     = {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
    reload_d = IDLE_TX_BYTE;
`ifdef SPI_BYTE_SLAVE_ECHO_EN
    reload_d = spi_input_q;
`endif
    // A pending result always wins; a same-cycle tx_load only affects the
    // following slot because tx_pending_q is still the old value here.
    if (tx_pending_q) reload_d = tx_pend_data_q;
  end

  // NOTE: reset is synchronous and covers every register, including both
  // shifters, so a reset mid-byte leaves no trace of the partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_sh_q        <= '0;
      tx_sh_q        <= '0;
      spi_input_q    <= '0;
      spi_done_q     <= 1'b0;
      miso_q         <= 1'b0;
      tx_pend_data_q <= '0;
      tx_pending_q   <= 1'b0;
    end else begin
      spi_done_q <= 1'b0;

      if (cs_rise) begin
        // Deselect aborts any partial byte without touching spi_input.
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            if (cs_fall) state_q <= LOAD;
          end
          LOAD: begin
            tx_sh_q      <= reload_d;
            miso_q       <= reload_d[SPI_BYTE_W-1];
            tx_pending_q <= 1'b0;
            state_q      <= SHIFT;
          end
          SHIFT: begin
            if (sclk_rise) begin
              rx_sh_q   <= rx_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                spi_input_q <= rx_d;
                spi_done_q  <= 1'b1;
                state_q     <= LOAD;
              end
            end else if (sclk_fall && bit_cnt_q != 3'd0) begin
              // The falling edge that trails a reload belongs to the previous
              // byte and must not shift away the new MSB.
              tx_sh_q <= {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
              miso_q  <= tx_sh_q[SPI_BYTE_W-2];
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // Placed last so a capture in the LOAD cycle overrides the clear above.
      if (bus.tx_load) begin
        tx_pend_data_q <= bus.tx_data;
        tx_pending_q   <= 1'b1;
      end
    end
  end

  assign bus.miso       = miso_q;
  assign bus.tx_pending = tx_pending_q;
  assign bus.spi_input  = spi_input_q;
  assign bus.spi_done   = spi_done_q;

endmodule

// File: tb/tb_spi_byte_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_slave
// Self-checking bench for spi_byte_slave. A host task drives mode-0 frames and
// samples miso; a byte-level model tracks the pending result, the last received
// byte and the expected spi_input sequence. A monitor checks spi_done/spi_input
// and idle miso every cycle. Honours SPI_BYTE_SLAVE_ECHO_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_byte_slave;
  import spi_pkg::*;

  localparam int SYNC  = 2;
  localparam int SETUP = 6;
  localparam int GAP   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_byte_slave_if bus_if ();

  spi_byte_slave #(.SYNC_STAGES(SYNC), .IDLE_TX_BYTE(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- byte-level reference model ----------------
  logic [7:0] m_pend;
  logic       m_pend_v;
  logic [7:0] m_last;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] fill_byte();
`ifdef SPI_BYTE_SLAVE_ECHO_EN
    return m_last;
`else
    return 8'h00;
`endif
  endfunction

  // ---------------- per-cycle monitor ----------------
  logic       mon_en = 1'b0;
  logic [7:0] held;
  logic       prev_done;
  int         dones_seen = 0;
  int         cs_hi_cnt  = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        held      = 8'h00;
        prev_done = 1'b0;
      end else begin
        if (bus_if.spi_done === 1'b1) begin
          dones_seen++;
          check("done_width", {31'd0, prev_done}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            held = exp_q.pop_front();
            check("spi_input_at_done", bus_if.spi_input, held);
          end
        end else begin
          check("spi_input_held", bus_if.spi_input, held);
        end
        prev_done = bus_if.spi_done;
        if (cs_hi_cnt > SYNC + 3) check("miso_idle", bus_if.miso, 0);
      end
      cs_hi_cnt = bus_if.cs_n ? cs_hi_cnt + 1 : 0;
    end
  end

  // ---------------- host side ----------------
  int         half = 6;
  logic [7:0] tx_bytes [4];
  logic [7:0] host_rx  [4];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] d);
    bus_if.tx_data = d;
    bus_if.tx_load = 1'b1;
    wait_clk(1);
    bus_if.tx_load = 1'b0;
    m_pend   = d;
    m_pend_v = 1'b1;
    wait_clk(2);
    check("tx_pending_set", bus_if.tx_pending, 1);
  endtask

  // nfull complete bytes followed by an optional partial byte of pbits bits.
  task automatic send_frame(input int nfull, input int pbits);
    logic [7:0] exp_tx, got;
    int         done0, nslots, nb;
    done0  = dones_seen;
    nslots = nfull + ((pbits > 0) ? 1 : 0);
    bus_if.cs_n = 1'b0;
    wait_clk(SETUP);
    for (int b = 0; b < nslots; b++) begin
      nb     = (b < nfull) ? 8 : pbits;
      exp_tx = m_pend_v ? m_pend : fill_byte();
      m_pend_v = 1'b0;
      if (b == 0) check("tx_pending_cleared", bus_if.tx_pending, 0);
      if (nb == 8) exp_q.push_back(tx_bytes[b]);
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        bus_if.mosi = tx_bytes[b][7-i];
        wait_clk(half);
        got = {got[6:0], bus_if.miso};
        bus_if.sclk = 1'b1;
        wait_clk(half);
        bus_if.sclk = 1'b0;
      end
      if (nb == 8) begin
        host_rx[b] = got;
        m_last     = tx_bytes[b];
        check("miso_byte", got, exp_tx);
      end
    end
    wait_clk(half + SETUP);
    bus_if.cs_n = 1'b1;
    bus_if.mosi = 1'b0;
    wait_clk(GAP);
    check("done_count", dones_seen - done0, nfull);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.sclk = 1'b0; bus_if.cs_n = 1'b1; bus_if.mosi = 1'b0;
    bus_if.tx_data = 8'h00; bus_if.tx_load = 1'b0;
    m_pend = 8'h00; m_pend_v = 1'b0; m_last = 8'h00;
    held = 8'h00; prev_done = 1'b0;
    wait_clk(4);
    check("rst_spi_input", bus_if.spi_input, 8'h00);
    check("rst_spi_done", bus_if.spi_done, 0);
    check("rst_miso", bus_if.miso, 0);
    check("rst_tx_pending", bus_if.tx_pending, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    wait_clk(4);

    // Single byte, nothing pending.
    tx_bytes[0] = 8'hA5;
    send_frame(1, 0);
    check("t1_spi_input", bus_if.spi_input, 8'hA5);
    check("t1_miso", host_rx[0], 8'h00);

    // Pending result read back.
    load_tx(8'h3C);
    tx_bytes[0] = 8'h81;
    send_frame(1, 0);
    check("t2_spi_input", bus_if.spi_input, 8'h81);
    check("t2_miso", host_rx[0], 8'h3C);
    check("t2_tx_pending", bus_if.tx_pending, 0);

    // Three bytes under one chip select.
    tx_bytes[0] = 8'hC0; tx_bytes[1] = 8'h12; tx_bytes[2] = 8'hFF;
    send_frame(3, 0);
    check("t3_spi_input", bus_if.spi_input, 8'hFF);

    // Aborted byte after 5 bits, then a full byte.
    tx_bytes[0] = 8'hF0;
    send_frame(0, 5);
    check("t4_spi_input_kept", bus_if.spi_input, 8'hFF);
    check("t4_bit_cnt", {29'd0, dut.bit_cnt_q}, 0);
    tx_bytes[0] = 8'h55;
    send_frame(1, 0);
    check("t4_spi_input", bus_if.spi_input, 8'h55);

    // Reset mid-byte with a result pending.
    bus_if.cs_n = 1'b0;
    wait_clk(SETUP);
    for (int i = 0; i < 3; i++) begin
      bus_if.mosi = 1'b1;
      wait_clk(half);
      bus_if.sclk = 1'b1;
      wait_clk(half);
      bus_if.sclk = 1'b0;
    end
    bus_if.tx_data = 8'h99; bus_if.tx_load = 1'b1;
    wait_clk(1);
    bus_if.tx_load = 1'b0;
    rst = 1'b1;
    wait_clk(2);
    check("t5_rst_spi_input", bus_if.spi_input, 8'h00);
    check("t5_rst_spi_done", bus_if.spi_done, 0);
    check("t5_rst_miso", bus_if.miso, 0);
    check("t5_rst_tx_pending", bus_if.tx_pending, 0);
    rst = 1'b0;
    m_pend_v = 1'b0; m_last = 8'h00;
    wait_clk(4);
    bus_if.cs_n = 1'b1; bus_if.mosi = 1'b0;
    wait_clk(GAP);
    check("t5_no_done", dones_seen, 6);
    tx_bytes[0] = 8'h7E;
    send_frame(1, 0);
    check("t5_spi_input", bus_if.spi_input, 8'h7E);

    // Loopback (or idle byte) on a frame with no pending result.
    tx_bytes[0] = 8'h5A;
    send_frame(1, 0);
    tx_bytes[0] = 8'h0F;
    send_frame(1, 0);
`ifdef SPI_BYTE_SLAVE_ECHO_EN
    check("t6_echo_miso", host_rx[0], 8'h5A);
`else
    check("t6_idle_miso", host_rx[0], 8'h00);
`endif

    // Last write wins on the pending register.
    load_tx(8'h11);
    load_tx(8'hE7);
    tx_bytes[0] = 8'h24;
    send_frame(1, 0);
    check("t7_overwrite_miso", host_rx[0], 8'hE7);

    // Randomized frames.
    for (int n = 0; n < 20; n++) begin
      int nfull, pbits;
      half = 5 + int'($urandom_range(3));
      if ($urandom_range(1) == 1) load_tx(8'($urandom));
      nfull = 1 + int'($urandom_range(2));
      pbits = ($urandom_range(4) == 0) ? 1 + int'($urandom_range(6)) : 0;
      for (int b = 0; b < 4; b++) tx_bytes[b] = 8'($urandom);
      send_frame(nfull, pbits);
    end

    wait_clk(GAP);
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
